// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper and its driver. The block under
// test sits on the far side of a..d/m.
interface truth_table_sweeper_if;
   logic        start;
   logic [15:0] expected;
   logic        m;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] truth;

   modport master (
      output start, expected, m,
      input  a, b, c, d, busy, done, pass, truth
   );

   modport slave (
      input  start, expected, m,
      output a, b, c, d, busy, done, pass, truth
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} vectors in ascending order, holds each one for
// HOLD_CYCLES, captures m at the end of every hold and checks the table.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, outputs at reset values
// ST_DRIVE | vector on a..d, hold counter running, m captured at hold end
// ST_CHECK | one cycle: compare captured table with latched expected
// ST_DONE  | result held until next start
module truth_table_sweeper #(
   parameter int HOLD_CYCLES = 20,
   parameter int CNT_W       = 8
) (
   input logic                  clk_i,
   input logic                  rst_i,
   truth_table_sweeper_if.slave sw
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || (HOLD_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_param
      $error("truth_table_sweeper: HOLD_CYCLES out of range for CNT_W");
   end

   state_t           state_q, state_d;
   logic [3:0]       vec_q,   vec_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [15:0]      truth_q, truth_d;
   logic [15:0]      exp_q,   exp_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             pass_q,  pass_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         vec_q   <= 4'd0;
         cnt_q   <= '0;
         truth_q <= 16'h0000;
         exp_q   <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         truth_q <= truth_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      truth_d = truth_q;
      exp_d   = exp_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (sw.start) begin
               state_d = ST_DRIVE;
               vec_d   = 4'd0;
               cnt_d   = '0;
               truth_d = 16'h0000;
               exp_d   = sw.expected;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d          = '0;
               truth_d[vec_q] = sw.m;
               // Vector stays at 15 through CHECK/DONE; no wrap inside a sweep.
               if (vec_q == 4'hF) begin
                  state_d = ST_CHECK;
               end else begin
                  vec_d = vec_q + 4'd1;
               end
            end
         end
         ST_CHECK: begin
            pass_d  = (truth_q == exp_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign sw.a     = vec_q[3];
   assign sw.b     = vec_q[2];
   assign sw.c     = vec_q[1];
   assign sw.d     = vec_q[0];
   assign sw.busy  = busy_q;
   assign sw.done  = done_q;
   assign sw.pass  = pass_q;
   assign sw.truth = truth_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream of the lab's 4-input combinational function blocks (inputs a,b,c,d; output m).
- On start, it drives all 16 input combinations in ascending order and holds each one for a programmable number of cycles.
- At the end of each hold it samples the block's output m into a 16-bit truth table.
- It then compares the completed table against an expected pattern and reports pass/fail. This replaces hand-written delay-based stimulus with a clocked, self-checking sweep.

Parameters:
- HOLD_CYCLES, 20, clock cycles each input vector is held; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- expected  input  16  reference truth table; bit i = required m for {a,b,c,d}=i; latched on accepted start.
- m  input  1  output of the block under test (combinational from a,b,c,d).
- a  output  1  stimulus MSB (vector bit 3).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus LSB (vector bit 0).
- busy  output  1  high while a sweep is in progress (DRIVE or CHECK).
- done  output  1  high from sweep completion until next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff captured table equals latched expected.
- truth  output  16  captured table; bit i = m sampled while {a,b,c,d}=i.

Behaviour:
- Reset (rst=1 at a rising edge, overrides everything):
  - state=IDLE.
  - a=b=c=d=0, busy=0, done=0, pass=0, truth=16'h0000.
  - Internal vector=0, counter=0, expected latch=0.
- States: IDLE, DRIVE, CHECK, DONE. {a,b,c,d} are always the registered 4-bit vector.
- IDLE, DONE, start=1:
  - Next state DRIVE.
  - vector=0, counter=0, truth=0, done=0, pass=0, busy=1.
  - expected latched.
- IDLE, DONE, start=0: hold state. In DONE, done, pass and truth are held.
- DRIVE, counter != HOLD_CYCLES-1: counter+1.
- DRIVE, counter == HOLD_CYCLES-1:
  - truth[vector] <= m; counter=0.
  - If vector==15: next state CHECK, vector stays 15.
  - Otherwise: vector+1 (no wrap inside a sweep).
- CHECK (exactly one cycle):
  - pass <= (truth == expected latch); done <= 1; busy <= 0.
  - Next state DONE.
- start while busy (DRIVE or CHECK) is ignored; expected changes after the latch are ignored.
- Timing, counting edge E0 as the edge that accepts start:
  - Vector k is driven from edge E0+k*H to edge E0+(k+1)*H, i.e. exactly H cycles each.
  - m is sampled at edge E0+(k+1)*H, where H=HOLD_CYCLES.
  - busy falls and done/pass become valid at edge E0+16*H+1.
- HOLD_CYCLES=1: sample every cycle; the vector advances every cycle.
- Reset mid-sweep: full reset values at that edge; no partial table is retained.
- truth bits for vectors not yet sampled read 0 during a sweep.

Test Plan:
1. Reset, HOLD_CYCLES=20, m tied 0, expected=16'h0000, start pulse → done=1 and busy=0 exactly 321 edges after the start edge; truth=16'h0000; pass=1.
2. m modelled as (a&b)|(c&d), expected=16'hF888 → truth=16'hF888, pass=1.
3. Same model, expected=16'hF889 → truth=16'hF888, pass=0, done=1.
4. Monitor {a,b,c,d} with HOLD_CYCLES=20:
   - Steps 0000→0001→…→1111, each value held exactly 20 cycles, no glitches.
   - Stays at 1111 through CHECK/DONE.
   - Repeat with HOLD_CYCLES=1: new vector every cycle, done 17 edges after start.
5. Start pulse while vector=5 → ignored, sweep timing unchanged. Assert rst while vector=9 → next edge a..d=0, busy=0, done=0, truth=0, and start is accepted normally afterwards.
6. From DONE (pass=1), start with expected=16'h0001 → done drops and truth clears on the start edge; the new sweep completes with pass=0.
